// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
// The clear sequencer and the top-level storage both import this package.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks an index over every register, one per clock.
// Emits busy/clear-enable while walking; a walk cannot be restarted once begun.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_idx_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // clr_i is deliberately ignored here; a held request re-arms from IDLE.
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o    = (state_q == ST_CLEAR);
    assign clr_en_o  = busy_o;
    assign clr_idx_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// NREG x XLEN register file: two combinational read ports, one synchronous write
// port, optional hardwired-zero r0, optional write-to-read bypass and soft clear.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic [AW-1:0]   rd_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] datord_i,
    input  logic            clr_i,
    output logic            busy_o,
    output logic            wr_drop_o,
    output logic [XLEN-1:0] dators1_o,
    output logic [XLEN-1:0] dators2_o
);

    // Storage is padded to a power of two so any address indexes a defined slot.
    localparam int            NSLOT  = 1 << AW;
    localparam logic [AW:0]   NREG_W = (AW + 1)'(NREG);

    logic                       busy;
    logic                       clr_en;
    logic [AW-1:0]              clr_idx;
    logic                       rd_in_range;
    logic                       rd_is_zero;
    logic                       wr_accept;
    logic                       wr_drop_d;
    logic                       wr_drop_q;
    logic [NSLOT-1:0][XLEN-1:0] regs_flat;

    regfile_clr_seq #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clr_seq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .busy_o    (busy),
        .clr_en_o  (clr_en),
        .clr_idx_o (clr_idx)
    );

    assign rd_in_range = ({1'b0, rd_i} < NREG_W);
    assign rd_is_zero  = (ZERO_REG != 0) && (rd_i == '0);
    assign wr_accept   = we_i && !busy && rd_in_range && !rd_is_zero;
    // A write to a hardwired r0 is discarded silently, so it never raises a drop.
    assign wr_drop_d   = we_i && (busy || !rd_in_range);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NREG && !(ZERO_REG != 0 && gi == 0)) begin : g_live
                localparam logic [AW-1:0] IDX = AW'(gi);
                logic [XLEN-1:0] slot_q;

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        slot_q <= '0;
                    end else if (clr_en && clr_idx == IDX) begin
                        slot_q <= '0;
                    end else if (wr_accept && rd_i == IDX) begin
                        slot_q <= datord_i;
                    end
                end

                assign regs_flat[gi] = slot_q;
            end else begin : g_tied
                assign regs_flat[gi] = '0;
            end
        end
    endgenerate

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]              rs,
        input logic [NSLOT-1:0][XLEN-1:0] regs,
        input logic                       busy_v,
        input logic                       accept_v,
        input logic [AW-1:0]              wa,
        input logic [XLEN-1:0]            wd
    );
        logic [XLEN-1:0] val;
        val = regs[rs];
        if (({1'b0, rs} >= NREG_W) || ((ZERO_REG != 0) && rs == '0) || busy_v) begin
            val = '0;
        end else if ((BYPASS != 0) && accept_v && wa == rs) begin
            val = wd;
        end
        return val;
    endfunction

    assign dators1_o = read_port(rs1_i, regs_flat, busy, wr_accept, rd_i, datord_i);
    assign dators2_o = read_port(rs2_i, regs_flat, busy, wr_accept, rd_i, datord_i);

    assign busy_o    = busy;
    assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and are
// checked against a register-array reference model, a vector table and hand sequences.
module tb_regfile_param;

    localparam int NINST = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        we, clr;
    logic [31:0] data;

    logic        busy [NINST];
    logic        drop [NINST];
    logic [31:0] r1   [NINST];
    logic [31:0] r2   [NINST];

    always #5 clk = ~clk;

    regfile_param dut0 (
        .clk_i(clk), .rst_ni(rst_n), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .we_i(we),
        .datord_i(data), .clr_i(clr), .busy_o(busy[0]), .wr_drop_o(drop[0]),
        .dators1_o(r1[0]), .dators2_o(r2[0])
    );

    regfile_param #(.ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .we_i(we),
        .datord_i(data), .clr_i(clr), .busy_o(busy[1]), .wr_drop_o(drop[1]),
        .dators1_o(r1[1]), .dators2_o(r2[1])
    );

    regfile_param #(.NREG(24)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .we_i(we),
        .datord_i(data), .clr_i(clr), .busy_o(busy[2]), .wr_drop_o(drop[2]),
        .dators1_o(r1[2]), .dators2_o(r2[2])
    );

    int tests = 0;
    int fails = 0;

    // Reference model: plain register contents plus "registers left to clear".
    logic [31:0] mreg  [NINST][32];
    bit          mbusy [NINST];
    int          mleft [NINST];
    bit          mdrop [NINST];

    function automatic int nreg_of(int k);
        return (k == 2) ? 24 : 32;
    endfunction

    function automatic bit zero_of(int k);
        return k != 1;
    endfunction

    function automatic bit byp_of(int k);
        return k != 1;
    endfunction

    function automatic bit accepted(int k);
        return we && !mbusy[k] && (int'(rd) < nreg_of(k)) && !(zero_of(k) && rd == 5'd0);
    endfunction

    function automatic logic [31:0] mread(int k, logic [4:0] a);
        if (int'(a) >= nreg_of(k) || (zero_of(k) && a == 5'd0) || mbusy[k]) return 32'h0;
        if (byp_of(k) && accepted(k) && rd == a) return data;
        return mreg[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NINST; k++) begin
            for (int i = 0; i < 32; i++) mreg[k][i] = 32'h0;
            mbusy[k] = 1'b0;
            mleft[k] = 0;
            mdrop[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        if (!rst_n) return;
        for (int k = 0; k < NINST; k++) begin
            acc      = accepted(k);
            mdrop[k] = we && (mbusy[k] || int'(rd) >= nreg_of(k));
            if (acc) mreg[k][rd] = data;
            if (mbusy[k]) begin
                mreg[k][nreg_of(k) - mleft[k]] = 32'h0;
                mleft[k]--;
                if (mleft[k] == 0) mbusy[k] = 1'b0;
            end else if (clr) begin
                mbusy[k] = 1'b1;
                mleft[k] = nreg_of(k);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NINST; k++) begin
            check($sformatf("model%0d.busy", k), 32'(busy[k]), 32'(mbusy[k]));
            check($sformatf("model%0d.drop", k), 32'(drop[k]), 32'(mdrop[k]));
            check($sformatf("model%0d.rs1", k), r1[k], mread(k, rs1));
            check($sformatf("model%0d.rs2", k), r2[k], mread(k, rs2));
        end
    endtask

    // Called at a falling edge: drive inputs, let them settle, compare.
    task automatic apply(input logic w, input logic [4:0] a_rd, input logic [31:0] d,
                         input logic c, input logic [4:0] a1, input logic [4:0] a2);
        we = w; rd = a_rd; data = d; clr = c; rs1 = a1; rs2 = a2;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp1_nb;
    } vec_t;

    vec_t tbl [7];
    bit   bseq [70];
    int   busy_cnt;

    initial begin
        // exp1/exp2 for the default instance, exp1_nb for the no-zero/no-bypass one.
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0, 32'h00001234, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h00001234};
        tbl[4] = '{1'b1, 5'd7, 32'h000000A5, 5'd7, 5'd5, 32'h000000A5, 32'hDEADBEEF, 32'h0};
        tbl[5] = '{1'b1, 5'd7, 32'h00000055, 5'd7, 5'd7, 32'h00000055, 32'h00000055, 32'h000000A5};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h00000055, 32'hDEADBEEF, 32'h00000055};

        rst_n = 1'b0; we = 1'b0; clr = 1'b0; rd = '0; rs1 = 5'd3; rs2 = 5'd4; data = '0;
        model_reset();
        #1;
        check_all();
        check("reset.busy", 32'(busy[0]), 32'h0);
        check("reset.drop", 32'(drop[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].we, tbl[i].rd, tbl[i].data, 1'b0, tbl[i].rs1, tbl[i].rs2);
            $display("[TB] vec %0d we=%0d rd=%0d rs1=%0d rs2=%0d -> %h %h", i, tbl[i].we,
                     tbl[i].rd, tbl[i].rs1, tbl[i].rs2, r1[0], r2[0]);
            check($sformatf("vec%0d.rs1", i), r1[0], tbl[i].exp1);
            check($sformatf("vec%0d.rs2", i), r2[0], tbl[i].exp2);
            check($sformatf("vec%0d.nb_rs1", i), r1[1], tbl[i].exp1_nb);
            check($sformatf("vec%0d.drop", i), 32'(drop[0]), 32'h0);
            tick();
        end

        // Out-of-range write on the 24-entry instance.
        apply(1'b1, 5'd30, 32'hCAFEF00D, 1'b0, 5'd30, 5'd30);
        $display("[TB] oob write rd=30 (NREG=24)");
        check("oob.rs2_24", r2[2], 32'h0);
        check("oob.rs1_32", r1[0], 32'hCAFEF00D);
        tick();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd30, 5'd30);
        check("oob.drop_24", 32'(drop[2]), 32'h1);
        check("oob.drop_32", 32'(drop[0]), 32'h0);
        check("oob.rs1_32_next", r1[0], 32'hCAFEF00D);
        tick();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        check("oob.drop_pulse", 32'(drop[2]), 32'h0);
        tick();

        // Fill, then soft-clear walk with a write issued mid-walk.
        for (int i = 1; i < 32; i++) begin
            apply(1'b1, 5'(i), (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5, 1'b0, 5'(i), 5'(i - 1));
            tick();
        end
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd1);
        $display("[TB] clear walk start");
        tick();
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            apply(c == 3, 5'd9, 32'h99999999, 1'b0, 5'(c), 5'd31);
            if (busy[0]) begin
                busy_cnt++;
                check("walk.rs1", r1[0], 32'h0);
            end
            if (c == 4) check("walk.drop", 32'(drop[0]), 32'h1);
            if (c == 5) check("walk.drop_pulse", 32'(drop[0]), 32'h0);
            tick();
        end
        $display("[TB] clear walk busy cycles %0d", busy_cnt);
        check("walk.busy_cycles", 32'(busy_cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(i));
            check("walk.after_rs1", r1[0], 32'h0);
            check("walk.after_nb", r1[1], 32'h0);
            tick();
        end

        // Asynchronous reset ten cycles into a walk.
        for (int i = 1; i < 32; i++) begin
            apply(1'b1, 5'(i), 32'h5A000000 | 32'(i), 1'b0, 5'(i), 5'd0);
            tick();
        end
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        tick();
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd30);
            tick();
        end
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd30);
        check("rst.busy_before", 32'(busy[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        $display("[TB] async reset mid-walk");
        check("rst.busy0", 32'(busy[0]), 32'h0);
        check("rst.busy2", 32'(busy[2]), 32'h0);
        check("rst.rs1_nb", r1[1], 32'h0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i));
            check("rst.after_rs1", r1[1], 32'h0);
            check("rst.after_busy", 32'(busy[0]), 32'h0);
            tick();
        end

        // clr_i held high: walks repeat with a single idle cycle between.
        for (int i = 0; i < 70; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2);
            bseq[i] = busy[0];
            tick();
        end
        $display("[TB] held clear sequence captured");
        check("held.c0", 32'(bseq[0]), 32'h0);
        check("held.c1", 32'(bseq[1]), 32'h1);
        check("held.c32", 32'(bseq[32]), 32'h1);
        check("held.c33", 32'(bseq[33]), 32'h0);
        check("held.c34", 32'(bseq[34]), 32'h1);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 99) < 2, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
